seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//   Time-multiplexed 8-digit seven-segment driver sitting directly downstream of data_route:
//   consumes the 32-bit word selected by data_route's display mux and drives board AN/SEG pins.
//   Shadow-buffered so a new value never tears mid-frame; optional leading-zero blanking.
// PARAMETERS
//   SCAN_DIV  100000  clk cycles each digit is lit (>=2); bench uses 4
//   CNT_W     17      prescaler width, must satisfy 2**CNT_W >= SCAN_DIV
// PORTS
//   clk        in   1   system clock, all logic on rising edge
//   rst        in   1   synchronous reset, active-low (0 = reset)
//   value_in   in   32  hex word to display; digit i = value_in[4i+3:4i], digit 0 rightmost
//   value_vld  in   1   1-cycle strobe: capture value_in into pending buffer
//   dp_mask    in   8   decimal point per digit, 1 = lit; sampled live, not buffered
//   blank_lz   in   1   1 = blank leading zero digits (digit 0 never blanked); sampled live
//   AN         out  8   digit enables, active-low, one-cold
//   SEG        out  8   {dp,g,f,e,d,c,b,a}, active-low
//   frame_tick out  1   1-cycle pulse when digit index wraps 7->0
// BEHAVIOUR
// - Reset (rst=0 at edge): AN=8'hFF, SEG=8'hFF, frame_tick=0, prescaler=0, idx=0,
//   shown=32'h0, pending=32'h0, pend_flag=0. All outputs registered.
// - Prescaler counts 0..SCAN_DIV-1 and wraps; "step" = cycle where prescaler==SCAN_DIV-1.
//   On step: idx <= idx+1 (3-bit, 7 wraps to 0).
// - Wrap (step with idx==7): frame_tick<=1 next cycle; if pend_flag, shown<=pending, pend_flag<=0.
// - value_vld: pending<=value_in, pend_flag<=1. If value_vld coincides with a wrap, value_in
//   commits to shown directly that edge and pend_flag ends 0. Back-to-back strobes: last wins.
// - Output stage (1-cycle latency from idx/shown): AN <= ~(8'b1<<idx); SEG[6:0] <= hex
//   pattern of nibble idx of shown; SEG[7] <= ~dp_mask[idx].
// - Hex table SEG (dp off): 0 C0,1 F9,2 A4,3 B0,4 99,5 92,6 82,7 F8,8 80,9 90,
//   A 88,b 83,C C6,d A1,E 86,F 8E.
// - Blanking: digit i (i>=1) blanked when blank_lz=1 and shown[31:4i]==0. Blanked digit:
//   AN=8'hFF, SEG=8'hFF for its whole slot (dp suppressed too). Value 0 shows single "0".
// - First cycle after reset release: AN=FE showing digit 0; each digit lit SCAN_DIV cycles,
//   full frame 8*SCAN_DIV cycles; AN never has two zeros simultaneously.
// - Reset mid-frame: immediate return to reset state on next edge; pending value discarded.
// TESTING (SCAN_DIV=4)
//   1 reset held 3 cycles, release, no vld -> AN FE,FD,FB..7F each 4 cycles, SEG=C0 every digit.
//   2 vld with 32'h0123_89AB mid-frame -> current frame unchanged; from next frame_tick
//     digit0..7 SEG = 83,88,90,80,B0,A4,F9,C0.
//   3 blank_lz=1, value 32'h0000_00F5 -> digits 0,1 show 92,8E; digits 2..7 AN=FF SEG=FF.
//   4 vld on the wrap cycle with 32'hFFFF_FFFF -> shown updates same edge, pend_flag=0,
//     next frame all digits 8E; also two vld in one frame -> only second value appears.
//   5 dp_mask=8'h01, value 0 -> digit0 SEG=40, others C0; frame_tick once per 32 cycles.
//   6 rst=0 while idx=5 and pend_flag=1 -> next edge AN=FF, SEG=FF; after release digit0 shows 0.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 8-digit multiplexed seven-segment driver with a
// shadow-buffered display word and optional leading-zero blanking.
//
// Ports:
//   clk, rst (sync, active-low)
//   value_in[31:0], value_vld : word to show, 1-cycle capture strobe
//   dp_mask[7:0], blank_lz    : live decimal points / leading-zero blank
//   AN[7:0], SEG[7:0]         : active-low digit enables and segments
//   frame_tick                : pulse after the digit index wraps 7->0
module seg7_scan_driver #(
  parameter int SCAN_DIV = 100000,
  parameter int CNT_W    = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value_in,
  input  logic        value_vld,
  input  logic [7:0]  dp_mask,
  input  logic        blank_lz,
  output logic [7:0]  AN,
  output logic [7:0]  SEG,
  output logic        frame_tick
);

  logic [CNT_W-1:0] presc;
  logic [2:0]       idx;
  logic [31:0]      shown;
  logic [31:0]      pending;
  logic             pend_flag;

  logic             step;
  logic             wrap;
  logic [3:0]       nib;
  logic [31:0]      upper;
  logic             blank;
  logic [7:0]       hex;
  logic [7:0]       an_d;
  logic [7:0]       seg_d;

  assign step = (presc == CNT_W'(SCAN_DIV - 1));
  assign wrap = step && (idx == 3'd7);

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc      <= '0;
      idx        <= 3'd0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= wrap;
      if (step) begin
        presc <= '0;
        idx   <= idx + 3'd1;
      end else begin
        presc <= presc + CNT_W'(1);
      end
    end
  end

  // shown only changes on the frame boundary, so a frame never tears.
  // A strobe landing on the boundary itself commits straight through.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shown     <= 32'h0;
      pending   <= 32'h0;
      pend_flag <= 1'b0;
    end else begin
      if (value_vld) begin
        pending <= value_in;
      end
      if (wrap && value_vld) begin
        shown     <= value_in;
        pend_flag <= 1'b0;
      end else if (wrap && pend_flag) begin
        shown     <= pending;
        pend_flag <= 1'b0;
      end else if (value_vld) begin
        pend_flag <= 1'b1;
      end
    end
  end

  always_comb begin
    nib   = shown[{idx, 2'b00} +: 4];
    upper = shown >> {idx, 2'b00};
    blank = blank_lz && (idx != 3'd0) && (upper == 32'h0);
    hex   = 8'hFF;
    unique case (nib)
      4'h0: hex = 8'hC0;
      4'h1: hex = 8'hF9;
      4'h2: hex = 8'hA4;
      4'h3: hex = 8'hB0;
      4'h4: hex = 8'h99;
      4'h5: hex = 8'h92;
      4'h6: hex = 8'h82;
      4'h7: hex = 8'hF8;
      4'h8: hex = 8'h80;
      4'h9: hex = 8'h90;
      4'hA: hex = 8'h88;
      4'hB: hex = 8'h83;
      4'hC: hex = 8'hC6;
      4'hD: hex = 8'hA1;
      4'hE: hex = 8'h86;
      4'hF: hex = 8'h8E;
    endcase
    an_d  = ~(8'b1 << idx);
    seg_d = {~dp_mask[idx], hex[6:0]};
    if (blank) begin
      an_d  = 8'hFF;
      seg_d = 8'hFF;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      AN  <= 8'hFF;
      SEG <= 8'hFF;
    end else begin
      AN  <= an_d;
      SEG <= seg_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed + random stimulus against a
// frame-level model of the seven-segment scan driver.
module tb_seg7_scan_driver;

  localparam int SCAN_DIV = 4;
  localparam int FRAME    = 8 * SCAN_DIV;

  localparam logic [7:0] HEX [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] value_in = '0;
  logic        value_vld = 1'b0;
  logic [7:0]  dp_mask = '0;
  logic        blank_lz = 1'b0;
  logic [7:0]  AN;
  logic [7:0]  SEG;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  int          e = 0;
  logic [31:0] latest = '0;
  logic [31:0] disp = '0;

  seg7_scan_driver #(
    .SCAN_DIV(SCAN_DIV),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .value_in(value_in),
    .value_vld(value_vld),
    .dp_mask(dp_mask),
    .blank_lz(blank_lz),
    .AN(AN),
    .SEG(SEG),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%h exp=%h", tag, e, got, exp);
    end
  endtask

  function automatic logic [15:0] model_out(logic [31:0] v, int d,
                                            logic [7:0] dp, logic blz);
    logic [31:0] hi;
    logic [7:0]  seg;
    hi = v >> (4 * d);
    if (blz && d > 0 && hi == 32'h0) return 16'hFFFF;
    seg    = HEX[hi[3:0]];
    seg[7] = ~dp[d];
    return {~(8'h1 << d), seg};
  endfunction

  // One clock edge: predict what the edge produces, advance the model.
  task automatic tick();
    logic [15:0] exp;
    logic        eft;
    @(posedge clk);
    if (!rst) begin
      exp    = 16'hFFFF;
      eft    = 1'b0;
      e      = 0;
      latest = '0;
      disp   = '0;
    end else begin
      exp = model_out(disp, (e / SCAN_DIV) % 8, dp_mask, blank_lz);
      eft = ((e % FRAME) == FRAME - 1);
      if (value_vld) latest = value_in;
      if ((e % FRAME) == FRAME - 1) disp = latest;
      e++;
    end
    #1;
    check("AN", {24'h0, AN}, {24'h0, exp[15:8]});
    check("SEG", {24'h0, SEG}, {24'h0, exp[7:0]});
    check("frame_tick", {31'h0, frame_tick}, {31'h0, eft});
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(logic [31:0] v);
    value_in  = v;
    value_vld = 1'b1;
    tick();
    value_vld = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    run(3);
    rst = 1'b1;
    run(FRAME);

    run(8);
    pulse(32'h0123_89AB);
    run(70);

    blank_lz = 1'b1;
    pulse(32'h0000_00F5);
    run(70);
    blank_lz = 1'b0;

    while ((e % FRAME) != FRAME - 1) tick();
    pulse(32'hFFFF_FFFF);
    run(40);

    run(3);
    pulse(32'h1111_1111);
    run(5);
    pulse(32'h2222_2222);
    run(60);

    dp_mask = 8'h01;
    pulse(32'h0);
    run(70);

    for (int i = 0; i < 600; i++) begin
      value_vld = ($urandom_range(0, 7) == 0);
      value_in  = $urandom >> $urandom_range(0, 31);
      dp_mask   = 8'($urandom);
      blank_lz  = 1'($urandom);
      tick();
    end
    value_vld = 1'b0;
    dp_mask   = 8'h00;
    blank_lz  = 1'b0;

    while ((e % FRAME) != 10) tick();
    pulse(32'hAAAA_5555);
    while ((e % FRAME) != 21) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    run(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
